// File: rtl/siggen_frame_ctrl.sv
// Frame scheduler for siggen: PREAMBLE -> PAYLOAD -> [CRC] -> GAP, one word per WORD_BITS clocks.
// Optional CRC-8 slot enabled by defining SIGGEN_FRAME_CRC_EN.
module siggen_frame_ctrl #(
  parameter int unsigned WORD_BITS      = 8,
  parameter int unsigned PREAMBLE_WORDS = 2,
  parameter int unsigned FRAME_WORDS    = 4,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter logic [7:0]  PREAMBLE_WORD  = 8'hAA,
  parameter logic [7:0]  FILL_WORD      = 8'h00,
  parameter logic [7:0]  IDLE_WORD      = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [7:0]  pattern_o,
  output logic        pattern_load_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic        underrun_o,
  output logic        frame_active_o,
  output logic [15:0] frame_count_o
);

  localparam int unsigned CntW     = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int unsigned MaxSlots = (PREAMBLE_WORDS > FRAME_WORDS) ? PREAMBLE_WORDS : FRAME_WORDS;
  localparam int unsigned SlotW    = (MaxSlots > 1) ? $clog2(MaxSlots) : 1;
  localparam int unsigned GapW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef SIGGEN_FRAME_CRC_EN
  typedef enum logic [2:0] {StIdle, StPreamble, StPayload, StCrc, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPreamble, StPayload, StGap} state_e;
`endif

  state_e           state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [7:0]       pattern_q, pattern_d;
  logic             load_q, load_d;
  logic             sof_q, sof_d;
  logic             underrun_q, underrun_d;
  logic [15:0]      count_q, count_d;

  logic       slot_end, last_pre, last_pay, start;
  logic [7:0] payload_word;

`ifdef SIGGEN_FRAME_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  assign slot_end     = (bit_cnt_q == CntW'(WORD_BITS - 1));
  assign last_pre     = (slot_q == SlotW'(PREAMBLE_WORDS - 1));
  assign last_pay     = (slot_q == SlotW'(FRAME_WORDS - 1));
  assign start        = enable_i && in_valid_i;
  assign payload_word = in_valid_i ? in_data_i : FILL_WORD;

  // Ready only on a boundary whose next slot is payload.
  assign in_ready_o = slot_end && ((state_q == StPreamble && last_pre) ||
                                   (state_q == StPayload && !last_pay));

`ifdef SIGGEN_FRAME_CRC_EN
  assign eof_o          = slot_end && (state_q == StCrc);
`else
  assign eof_o          = slot_end && (state_q == StPayload) && last_pay;
`endif
  assign frame_active_o = (state_q != StIdle) && (state_q != StGap);

  assign pattern_o      = pattern_q;
  assign pattern_load_o = load_q;
  assign sof_o          = sof_q;
  assign underrun_o     = underrun_q;
  assign frame_count_o  = count_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    slot_d     = slot_q;
    gap_d      = gap_q;
    pattern_d  = pattern_q;
    load_d     = 1'b0;
    sof_d      = 1'b0;
    underrun_d = 1'b0;
    count_d    = count_q + 16'(eof_o);
`ifdef SIGGEN_FRAME_CRC_EN
    crc_d      = crc_q;
`endif

    if (frame_active_o) begin
      bit_cnt_d = slot_end ? '0 : bit_cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        pattern_d = IDLE_WORD;
        if (start) begin
          state_d   = StPreamble;
          slot_d    = '0;
          bit_cnt_d = '0;
          pattern_d = PREAMBLE_WORD;
          load_d    = 1'b1;
          sof_d     = 1'b1;
`ifdef SIGGEN_FRAME_CRC_EN
          crc_d     = 8'h00;
`endif
        end
      end
      StPreamble: begin
        if (slot_end) begin
          load_d = 1'b1;
          if (last_pre) begin
            state_d    = StPayload;
            slot_d     = '0;
            pattern_d  = payload_word;
            underrun_d = !in_valid_i;
`ifdef SIGGEN_FRAME_CRC_EN
            crc_d      = crc8_next(crc_q, payload_word);
`endif
          end else begin
            slot_d    = slot_q + SlotW'(1);
            pattern_d = PREAMBLE_WORD;
          end
        end
      end
      StPayload: begin
        if (slot_end) begin
          if (!last_pay) begin
            slot_d     = slot_q + SlotW'(1);
            load_d     = 1'b1;
            pattern_d  = payload_word;
            underrun_d = !in_valid_i;
`ifdef SIGGEN_FRAME_CRC_EN
            crc_d      = crc8_next(crc_q, payload_word);
`endif
          end else begin
`ifdef SIGGEN_FRAME_CRC_EN
            state_d   = StCrc;
            load_d    = 1'b1;
            pattern_d = crc_q;
`else
            state_d   = StGap;
            gap_d     = '0;
            pattern_d = IDLE_WORD;
`endif
          end
        end
      end
`ifdef SIGGEN_FRAME_CRC_EN
      StCrc: begin
        if (slot_end) begin
          state_d   = StGap;
          gap_d     = '0;
          pattern_d = IDLE_WORD;
        end
      end
`endif
      StGap: begin
        pattern_d = IDLE_WORD;
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          if (start) begin
            state_d   = StPreamble;
            slot_d    = '0;
            bit_cnt_d = '0;
            pattern_d = PREAMBLE_WORD;
            load_d    = 1'b1;
            sof_d     = 1'b1;
`ifdef SIGGEN_FRAME_CRC_EN
            crc_d     = 8'h00;
`endif
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      slot_q     <= '0;
      gap_q      <= '0;
      pattern_q  <= IDLE_WORD;
      load_q     <= 1'b0;
      sof_q      <= 1'b0;
      underrun_q <= 1'b0;
      count_q    <= '0;
`ifdef SIGGEN_FRAME_CRC_EN
      crc_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_q     <= slot_d;
      gap_q      <= gap_d;
      pattern_q  <= pattern_d;
      load_q     <= load_d;
      sof_q      <= sof_d;
      underrun_q <= underrun_d;
      count_q    <= count_d;
`ifdef SIGGEN_FRAME_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_siggen_frame_ctrl.sv
// Directed bench for siggen_frame_ctrl; frame length expectations follow SIGGEN_FRAME_CRC_EN.
module tb_siggen_frame_ctrl;

  localparam int WB  = 8;
  localparam int GAP = 16;
`ifdef SIGGEN_FRAME_CRC_EN
  localparam int FLEN  = 56;
  localparam int NSLOT = 7;
`else
  localparam int FLEN  = 48;
  localparam int NSLOT = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  pattern;
  logic        pattern_load, sof, eof, underrun, frame_active;
  logic [15:0] frame_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  siggen_frame_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .pattern_o      (pattern),
    .pattern_load_o (pattern_load),
    .sof_o          (sof),
    .eof_o          (eof),
    .underrun_o     (underrun),
    .frame_active_o (frame_active),
    .frame_count_o  (frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observes one frame; drops in_valid at boundary number 'drop' (-1 = never).
  task automatic run_frame(input logic [31:0] words, input int drop,
                           output int sof_c, output int eof_c, output logic [63:0] slots,
                           output int nload, output int badload, output int nunder,
                           output int under_slot, output int prebad, output bit timeout);
    int  b, k;
    bit  in_frame;
    b = 0; k = 0; in_frame = 0;
    sof_c = -1; eof_c = -1; slots = '0; nload = 0; badload = 0; nunder = 0;
    under_slot = -1; prebad = 0; timeout = 1;
    enable = 1'b1; in_valid = 1'b1; in_data = words[31:24];
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sof) begin
        in_frame = 1;
        sof_c = cyc;
      end
      if (!in_frame) begin
        if (pattern_load || pattern != 8'h00 || frame_active) prebad++;
      end else begin
        if (underrun) begin
          nunder++;
          under_slot = k;
        end
        if (pattern_load) begin
          nload++;
          if ((cyc - sof_c) % WB != 0) badload++;
          if (k < 8) slots[8*k +: 8] = pattern;
          k++;
        end
      end
      in_valid = 1'b1;
      if (in_ready) begin
        in_valid = (b != drop);
        if (b < 4) in_data = words[31-8*b -: 8];
        b++;
      end
      if (in_frame && eof) begin
        eof_c = cyc;
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int nsof, nrdy, nact;
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (pattern !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_pattern: got %h want 00", pattern);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    vectors++;
    if (frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_frame_count: got %0d want 0", frame_count);
    end
    vectors++;
    if ({sof, eof, pattern_load, underrun, frame_active} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b want 00000",
               {sof, eof, pattern_load, underrun, frame_active});
    end
    rst_n = 1'b1; in_valid = 1'b1;
    nsof = 0; nrdy = 0; nact = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sof) nsof++;
      if (in_ready) nrdy++;
      if (frame_active || pattern != 8'h00) nact++;
    end
    vectors++;
    if (nsof != 0 || nrdy != 0 || nact != 0) begin
      miscompares++;
      $display("FAIL disabled_idle: got sof=%0d ready=%0d active=%0d want 0/0/0", nsof, nrdy, nact);
    end
  endtask

  task automatic test_nominal();
    int s, e, nl, bl, nu, us, pb;
    logic [63:0] sl;
    bit to;
    run_frame(32'h9A112233, -1, s, e, sl, nl, bl, nu, us, pb, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL nominal_timeout: got no eof want eof");
    end
    vectors++;
    if (e - s + 1 != FLEN) begin
      miscompares++;
      $display("FAIL nominal_length: got %0d want %0d", e - s + 1, FLEN);
    end
    vectors++;
    if (sl[47:0] !== 48'h3322119AAAAA) begin
      miscompares++;
      $display("FAIL nominal_slots: got %h want 3322119aaaaa", sl[47:0]);
    end
    vectors++;
    if (nl != NSLOT || bl != 0) begin
      miscompares++;
      $display("FAIL nominal_loads: got %0d loads %0d misplaced want %0d/0", nl, bl, NSLOT);
    end
    vectors++;
    if (nu != 0) begin
      miscompares++;
      $display("FAIL nominal_underrun: got %0d want 0", nu);
    end
    enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL nominal_count: got %0d want 1", frame_count);
    end
  endtask

  task automatic test_underrun();
    int s, e, nl, bl, nu, us, pb;
    logic [63:0] sl;
    bit to;
    run_frame(32'h44556677, 2, s, e, sl, nl, bl, nu, us, pb, to);
    vectors++;
    if (to || e - s + 1 != FLEN) begin
      miscompares++;
      $display("FAIL underrun_length: got %0d (timeout %0b) want %0d", e - s + 1, to, FLEN);
    end
    vectors++;
    if (sl[47:0] !== 48'h77005544AAAA) begin
      miscompares++;
      $display("FAIL underrun_slots: got %h want 77005544aaaa", sl[47:0]);
    end
    vectors++;
    if (nu != 1 || us != 4) begin
      miscompares++;
      $display("FAIL underrun_pulse: got %0d pulses at slot %0d want 1 at 4", nu, us);
    end
    enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (frame_count !== 16'd2) begin
      miscompares++;
      $display("FAIL underrun_count: got %0d want 2", frame_count);
    end
  endtask

  task automatic test_back_to_back();
    int s1, e1, s2, e2, nl, bl, nu, us, pb;
    logic [63:0] sl;
    bit to1, to2;
    run_frame(32'hC3C3C3C3, -1, s1, e1, sl, nl, bl, nu, us, pb, to1);
    run_frame(32'h0F1E2D3C, -1, s2, e2, sl, nl, bl, nu, us, pb, to2);
    vectors++;
    if (to1 || to2 || s2 - e1 != GAP + 1) begin
      miscompares++;
      $display("FAIL b2b_spacing: got sof-eof=%0d (timeout %0b%0b) want %0d",
               s2 - e1, to1, to2, GAP + 1);
    end
    vectors++;
    if (pb != 0) begin
      miscompares++;
      $display("FAIL b2b_gap_idle: got %0d active gap clocks want 0", pb);
    end
    vectors++;
    if (sl[47:0] !== 48'h3C2D1E0FAAAA || e2 - s2 + 1 != FLEN) begin
      miscompares++;
      $display("FAIL b2b_second: got %h len %0d want 3c2d1e0faaaa len %0d",
               sl[47:0], e2 - s2 + 1, FLEN);
    end
    enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (frame_count !== 16'd4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d want 4", frame_count);
    end
  endtask

`ifdef SIGGEN_FRAME_CRC_EN
  task automatic test_crc();
    int s, e, nl, bl, nu, us, pb;
    logic [63:0] sl;
    bit to;
    run_frame(32'h01000000, -1, s, e, sl, nl, bl, nu, us, pb, to);
    vectors++;
    if (sl[55:48] !== 8'h16) begin
      miscompares++;
      $display("FAIL crc_value: got %h want 16", sl[55:48]);
    end
    vectors++;
    if (to || e - s + 1 != 56) begin
      miscompares++;
      $display("FAIL crc_length: got %0d want 56", e - s + 1);
    end
    enable = 1'b0;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_frame();
    bit seen;
    int neof;
    seen = 0;
    enable = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sof) begin
        seen = 1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL midreset_start: got no sof want sof");
    end
    repeat (27) @(negedge clk);
    vectors++;
    if (frame_active !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_active: got %b want 1", frame_active);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (pattern !== 8'h00 || frame_active !== 1'b0 || in_ready !== 1'b0 ||
        {sof, eof, pattern_load, underrun} !== 4'b0 || frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got pat=%h act=%b rdy=%b pulses=%b cnt=%0d want 00/0/0/0000/0",
               pattern, frame_active, in_ready, {sof, eof, pattern_load, underrun}, frame_count);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    neof = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (eof || sof) neof++;
    end
    vectors++;
    if (neof != 0 || frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL midreset_after: got %0d pulses cnt=%0d want 0/0", neof, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underrun();
    test_back_to_back();
`ifdef SIGGEN_FRAME_CRC_EN
    test_crc();
`endif
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
